// File: rtl/console_pkg.sv
// Shared constants and types for the UART-to-VGA text console.
// Character codes, controller states and byte classification.
package console_pkg;

  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_TAB   = 8'h09;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_FF    = 8'h0C;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_DEL   = 8'h7F;

  typedef enum logic [1:0] {
    CLR_ALL,
    IDLE,
    CLR_ROW
  } state_e;

  function automatic logic is_print(input logic [7:0] c);
    return (c >= CHR_SPACE) && (c != CHR_DEL);
  endfunction

endpackage

// File: rtl/vga_console_ctrl_if.sv
// Byte-stream handshake plus text-buffer write port of the console.
// The controller is the slave side; source and buffer sit on master.
interface vga_console_ctrl_if #(
  parameter int ROW_W = 6,
  parameter int COL_W = 8
);

  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [ROW_W+COL_W-1:0] vga_waddr;
  logic [7:0]             vga_wdata;
  logic                   vga_wr_en;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  vga_waddr,
    input  vga_wdata,
    input  vga_wr_en
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output vga_waddr,
    output vga_wdata,
    output vga_wr_en
  );

endinterface

// File: rtl/vga_console_ctrl.sv
// Terminal sequencer: UART bytes in, text-buffer writes out.
// Tracks cursor, wraps, scrolls and clears rows as they are entered.
module vga_console_ctrl
  import console_pkg::*;
#(
  parameter int COLS     = 160,
  parameter int ROWS     = 64,
  parameter int VIS_ROWS = 60,
  parameter int COL_W    = 8,
  parameter int ROW_W    = 6
) (
  input  logic             clk48,
  input  logic             rst_n,
  vga_console_ctrl_if.slave bus,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic [ROW_W-1:0] scroll_row,
  output logic             busy
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W:0]   COLS_V   = (COL_W+1)'(COLS);
  localparam logic [ROW_W:0]   VIS_LIM  = (ROW_W+1)'(VIS_ROWS);

  state_e state_q, state_d;

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] scr_q, scr_d;

  logic [ROW_W-1:0] clr_row_q, clr_row_d;
  logic [COL_W-1:0] clr_col_q, clr_col_d;
  logic             clr_last_q, clr_last_d;

  logic                   we_q, we_d;
  logic [ROW_W+COL_W-1:0] waddr_q, waddr_d;
  logic [7:0]             wdata_q, wdata_d;

  logic [ROW_W-1:0] nl_row;
  logic [ROW_W-1:0] nl_dist;
  logic [COL_W:0]   tab_col;
  logic             nl;
  logic [7:0]       b;

  assign b       = bus.in_data;
  assign nl_row  = row_q + 1'b1;
  assign nl_dist = nl_row - scr_q;
  assign tab_col = {1'b0, col_q | COL_W'(7)} + 1'b1;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    scr_d      = scr_q;
    clr_row_d  = clr_row_q;
    clr_col_d  = clr_col_q;
    clr_last_d = clr_last_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    nl         = 1'b0;

    unique case (state_q)
      CLR_ALL, CLR_ROW: begin
        if (clr_last_q) begin
          state_d    = IDLE;
          clr_last_d = 1'b0;
        end else begin
          we_d    = 1'b1;
          waddr_d = {clr_row_q, clr_col_q};
          wdata_d = CHR_SPACE;
          if (clr_col_q == COL_LAST) begin
            clr_col_d = '0;
            if (state_q == CLR_ROW || clr_row_q == ROW_LAST)
              clr_last_d = 1'b1;
            else
              clr_row_d = clr_row_q + 1'b1;
          end else begin
            clr_col_d = clr_col_q + 1'b1;
          end
        end
      end

      IDLE: begin
        if (bus.in_valid) begin
          unique case (1'b1)
            is_print(b): begin
              we_d    = 1'b1;
              waddr_d = {row_q, col_q};
              wdata_d = b;
              if (col_q == COL_LAST)
                nl = 1'b1;
              else
                col_d = col_q + 1'b1;
            end
            b == CHR_CR: col_d = '0;
            b == CHR_LF: nl = 1'b1;
            b == CHR_BS: begin
              if (col_q != '0) begin
                col_d   = col_q - 1'b1;
                we_d    = 1'b1;
                waddr_d = {row_q, col_q - 1'b1};
                wdata_d = CHR_SPACE;
              end
            end
            b == CHR_TAB: begin
              if (tab_col >= COLS_V)
                nl = 1'b1;
              else
                col_d = tab_col[COL_W-1:0];
            end
            b == CHR_FF: begin
              row_d      = '0;
              col_d      = '0;
              scr_d      = '0;
              state_d    = CLR_ALL;
              we_d       = 1'b1;
              waddr_d    = '0;
              wdata_d    = CHR_SPACE;
              clr_row_d  = '0;
              clr_col_d  = COL_W'(1);
              clr_last_d = 1'b0;
            end
            default: ;
          endcase

          // A pending character write defers the first clear by a cycle.
          if (nl) begin
            row_d      = nl_row;
            col_d      = '0;
            state_d    = CLR_ROW;
            clr_row_d  = nl_row;
            clr_last_d = 1'b0;
            if ({1'b0, nl_dist} >= VIS_LIM)
              scr_d = scr_q + 1'b1;
            if (we_d) begin
              clr_col_d = '0;
            end else begin
              we_d      = 1'b1;
              waddr_d   = {nl_row, {COL_W{1'b0}}};
              wdata_d   = CHR_SPACE;
              clr_col_d = COL_W'(1);
            end
          end
        end
      end

      default: state_d = CLR_ALL;
    endcase
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLR_ALL;
      row_q      <= '0;
      col_q      <= '0;
      scr_q      <= '0;
      clr_row_q  <= '0;
      clr_col_q  <= '0;
      clr_last_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      scr_q      <= scr_d;
      clr_row_q  <= clr_row_d;
      clr_col_q  <= clr_col_d;
      clr_last_q <= clr_last_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.vga_waddr = waddr_q;
  assign bus.vga_wdata = wdata_q;
  assign bus.vga_wr_en = we_q;

  assign busy       = (state_q != IDLE);
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign scroll_row = scr_q;

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Scoreboard bench for vga_console_ctrl: expected writes are queued
// by the stimulus and popped by a negedge monitor.
module tb_vga_console_ctrl;
  import console_pkg::*;

  localparam int COLS  = 160;
  localparam int ROWS  = 64;
  localparam int BOUND = 20000;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic       clk48 = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] cursor_row;
  logic [7:0] cursor_col;
  logic [5:0] scroll_row;
  logic       busy;

  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;
  wr_t sb[$];

  vga_console_ctrl_if #(.ROW_W(6), .COL_W(8)) bus ();

  vga_console_ctrl #(
    .COLS(160), .ROWS(64), .VIS_ROWS(60), .COL_W(8), .ROW_W(6)
  ) dut (
    .clk48      (clk48),
    .rst_n      (rst_n),
    .bus        (bus),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .scroll_row (scroll_row),
    .busy       (busy)
  );

  always #5 clk48 = ~clk48;
  always @(posedge clk48) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [5:0] r, input logic [7:0] c,
                      input logic [7:0] d);
    wr_t e;
    e.addr = {r, c};
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic push_row(input logic [5:0] r);
    for (int c = 0; c < COLS; c++) push(r, 8'(c), CHR_SPACE);
  endtask

  task automatic push_all();
    for (int r = 0; r < ROWS; r++) push_row(6'(r));
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < BOUND) begin
      @(posedge clk48); #1;
      n++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0, expected 1");
    end
    @(posedge clk48); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.in_ready && n < BOUND) begin
      @(posedge clk48); #1;
      n++;
    end
  endtask

  always @(negedge clk48) begin
    wr_t got;
    wr_t exp_w;
    if (rst_n && bus.vga_wr_en) begin
      got.addr = bus.vga_waddr;
      got.data = bus.vga_wdata;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected: got addr=%h data=%h, expected none",
                 got.addr, got.data);
      end else begin
        exp_w = sb.pop_front();
        if (got !== exp_w) begin
          fails++;
          $display("FAIL wr_data: got addr=%h data=%h, expected addr=%h data=%h",
                   got.addr, got.data, exp_w.addr, exp_w.data);
        end
      end
    end
  end

  initial begin
    int n, t0, t1, t2;
    logic [7:0] ch;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    #3;
    chk("rst_wr_en", bus.vga_wr_en, 0);
    chk("rst_waddr", bus.vga_waddr, 0);
    chk("rst_wdata", bus.vga_wdata, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_cur_row", cursor_row, 0);
    chk("rst_cur_col", cursor_col, 0);
    chk("rst_scroll", scroll_row, 0);

    push_all();
    @(negedge clk48);
    rst_n = 1'b1;
    wait_ready(n);
    chk("clr_all_cycles", n, ROWS * COLS + 1);
    chk("clr_all_drained", sb.size(), 0);
    chk("post_clr_row", cursor_row, 0);
    chk("post_clr_col", cursor_col, 0);

    push(0, 0, 8'h41);
    push(0, 1, 8'h42);
    send(8'h41); t0 = cyc;
    send(8'h42); t1 = cyc;
    send(CHR_CR); t2 = cyc;
    chk("ab_back2back", t1 - t0, 1);
    chk("cr_back2back", t2 - t1, 1);
    chk("cr_col", cursor_col, 0);
    chk("cr_ready", bus.in_ready, 1);

    send(CHR_BS);
    chk("bs0_col", cursor_col, 0);
    chk("bs0_wr_en", bus.vga_wr_en, 0);

    push(0, 0, 8'h78);
    push(0, 1, 8'h79);
    push(0, 2, 8'h7A);
    send(8'h78);
    send(8'h79);
    send(8'h7A);
    chk("xyz_col", cursor_col, 3);
    push(0, 2, CHR_SPACE);
    send(CHR_BS);
    chk("bs3_col", cursor_col, 2);
    chk("bs3_wr_en", bus.vga_wr_en, 1);

    send(8'h01);
    send(CHR_DEL);
    chk("ctl_nop_col", cursor_col, 2);
    chk("ctl_nop_row", cursor_row, 0);

    send(CHR_CR);
    for (int i = 0; i < 5; i++) begin
      ch = 8'h41 + 8'(i);
      push(0, 8'(i), ch);
      send(ch);
    end
    chk("pre_lf_col", cursor_col, 5);
    push_row(1);
    send(CHR_LF);
    chk("lf_row", cursor_row, 1);
    chk("lf_col", cursor_col, 0);
    chk("lf_ready_low", bus.in_ready, 0);
    chk("lf_first_clear", bus.vga_wr_en, 1);
    wait_ready(n);
    chk("lf_busy_cycles", n, 160);
    chk("lf_drained", sb.size(), 0);

    for (int i = 0; i < COLS; i++) push(1, 8'(i), 8'h41 + 8'(i % 26));
    push_row(2);
    for (int i = 0; i < COLS; i++) begin
      send(8'h41 + 8'(i % 26));
      if (i == 0) t0 = cyc;
    end
    t1 = cyc;
    chk("wrap_stream_rate", t1 - t0, COLS - 1);
    chk("wrap_row", cursor_row, 2);
    chk("wrap_col", cursor_col, 0);
    wait_ready(n);
    chk("wrap_busy_cycles", n, 161);

    for (int r = 3; r <= 59; r++) begin
      push_row(6'(r));
      send(CHR_LF);
      wait_ready(n);
    end
    chk("row59", cursor_row, 59);
    chk("row59_scroll", scroll_row, 0);
    push_row(60);
    send(CHR_LF);
    wait_ready(n);
    chk("row60", cursor_row, 60);
    chk("row60_scroll", scroll_row, 1);
    for (int r = 61; r <= 63; r++) begin
      push_row(6'(r));
      send(CHR_LF);
      wait_ready(n);
    end
    chk("row63_scroll", scroll_row, 4);
    push_row(0);
    send(CHR_LF);
    wait_ready(n);
    chk("wrap0_row", cursor_row, 0);
    chk("wrap0_scroll", scroll_row, 5);

    send(CHR_TAB);
    chk("tab_col8", cursor_col, 8);
    for (int i = 0; i < 18; i++) send(CHR_TAB);
    chk("tab_col152", cursor_col, 152);
    for (int i = 0; i < 5; i++) begin
      push(0, 8'(152 + i), 8'h61 + 8'(i));
      send(8'h61 + 8'(i));
    end
    chk("tab_col157", cursor_col, 157);
    push_row(1);
    send(CHR_TAB);
    chk("tab_nl_row", cursor_row, 1);
    chk("tab_nl_col", cursor_col, 0);
    chk("tab_nl_scroll", scroll_row, 6);
    wait_ready(n);
    chk("tab_nl_cycles", n, 160);

    push(1, 0, 8'h51);
    send(8'h51);
    chk("ff_pre_col", cursor_col, 1);
    push_all();
    send(CHR_FF);
    chk("ff_row", cursor_row, 0);
    chk("ff_col", cursor_col, 0);
    chk("ff_scroll", scroll_row, 0);
    chk("ff_ready_low", bus.in_ready, 0);
    chk("ff_first_clear", bus.vga_wr_en, 1);
    wait_ready(n);
    chk("ff_cycles", n, ROWS * COLS);
    chk("ff_drained", sb.size(), 0);

    push_row(1);
    send(CHR_LF);
    repeat (20) @(posedge clk48);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", bus.vga_wr_en, 0);
    chk("midrst_row", cursor_row, 0);
    chk("midrst_busy", busy, 1);
    sb.delete();
    push_all();
    @(negedge clk48);
    rst_n = 1'b1;
    wait_ready(n);
    chk("midrst_clr_cycles", n, ROWS * COLS + 1);
    chk("midrst_row_after", cursor_row, 0);
    chk("midrst_scroll", scroll_row, 0);

    repeat (2) @(posedge clk48);
    #1;
    chk("final_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
